decode_stage: RTL and testbench

Instruction-decode stage of the 5-stage MIPS core, upstream of the execute stage. It holds the 32x32 register file, the main/ALU control decoder, the sign extender and early branch/jump resolution. It also contains the ID/EX pipeline register that drives the execute stage's E-side inputs: control, operands, register specifiers and immediate. Branches resolve in decode, with M-stage forwarding supplied by the hazard unit.

---
 rtl/decode_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS instruction-decode stage with register file, control decode, branch resolution and ID/EX register
//
// Ports:
//   clk, rst            core clock; asynchronous active-low reset
//   instrD, pcPlus4D    instruction and PC+4 from the IF/ID register
//   regWriteW, writeRegW, resultW   write-back port into the register file
//   aluOutM             M-stage ALU result for branch-compare forwarding
//   forwardAD/BD        select aluOutM for comparator operand A/B
//   flushE              clear the ID/EX register (bubble)
//   rsD, rtD            source specifiers to the hazard unit
//   branchD, jumpD      decoded branch/jump flags
//   pcSrcD              branch taken
//   pcBranchD, pcJumpD  branch and jump targets
//   *E outputs          registered controls, operands, specifiers, immediate

module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic [31:0] pcPlus4D,
    input  logic        regWriteW,
    input  logic [4:0]  writeRegW,
    input  logic [31:0] resultW,
    input  logic [31:0] aluOutM,
    input  logic        forwardAD,
    input  logic        forwardBD,
    input  logic        flushE,
    output logic [4:0]  rsD,
    output logic [4:0]  rtD,
    output logic        branchD,
    output logic        jumpD,
    output logic        pcSrcD,
    output logic [31:0] pcBranchD,
    output logic [31:0] pcJumpD,
    output logic        regWriteE,
    output logic        memToRegE,
    output logic        memWriteE,
    output logic        aluSrcE,
    output logic        regDstE,
    output logic [1:0]  aluControlE,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [4:0]  rsE,
    output logic [4:0]  rtE,
    output logic [4:0]  rdE,
    output logic [31:0] signImmE
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;

    logic [31:0] r_regs [32];

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rd;
    logic [31:0] w_sign_imm;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [31:0] w_cmp_a;
    logic [31:0] w_cmp_b;
    logic        w_equal;
    logic        w_wr_en;

    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic        w_mem_write;
    logic        w_alu_src;
    logic        w_reg_dst;
    logic [1:0]  w_alu_control;
    logic        w_branch;
    logic        w_jump;

    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic        r_mem_write;
    logic        r_alu_src;
    logic        r_reg_dst;
    logic [1:0]  r_alu_control;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [31:0] r_sign_imm;

    assign w_opcode   = instrD[31:26];
    assign w_funct    = instrD[5:0];
    assign rsD        = instrD[25:21];
    assign rtD        = instrD[20:16];
    assign w_rd       = instrD[15:11];
    assign w_sign_imm = {{16{instrD[15]}}, instrD[15:0]};

    // Writes to r0 are dropped here, so r0 never holds anything but zero.
    assign w_wr_en = regWriteW && (writeRegW != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_wr_en) begin
            r_regs[writeRegW] <= resultW;
        end
    end

    // Write-through lets an instruction in decode see the value being
    // written back in the same cycle, so no extra W->D forwarding is needed.
    always_comb begin
        w_rd1 = 32'd0;
        if (rsD != 5'd0) begin
            if (w_wr_en && (writeRegW == rsD)) begin
                w_rd1 = resultW;
            end else begin
                w_rd1 = r_regs[rsD];
            end
        end
    end

    always_comb begin
        w_rd2 = 32'd0;
        if (rtD != 5'd0) begin
            if (w_wr_en && (writeRegW == rtD)) begin
                w_rd2 = resultW;
            end else begin
                w_rd2 = r_regs[rtD];
            end
        end
    end

    always_comb begin
        w_reg_write   = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_mem_write   = 1'b0;
        w_alu_src     = 1'b0;
        w_reg_dst     = 1'b0;
        w_alu_control = 2'b00;
        w_branch      = 1'b0;
        w_jump        = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                // Unsupported funct codes decode as a bubble, not as ADD.
                case (w_funct)
                    FN_ADD: begin w_reg_write = 1'b1; w_reg_dst = 1'b1; w_alu_control = 2'b00; end
                    FN_SUB: begin w_reg_write = 1'b1; w_reg_dst = 1'b1; w_alu_control = 2'b01; end
                    FN_AND: begin w_reg_write = 1'b1; w_reg_dst = 1'b1; w_alu_control = 2'b10; end
                    FN_OR:  begin w_reg_write = 1'b1; w_reg_dst = 1'b1; w_alu_control = 2'b11; end
                    default: ;
                endcase
            end
            OP_LW: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            OP_SW: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_BEQ: begin
                w_branch      = 1'b1;
                w_alu_control = 2'b01;
            end
            OP_ADDI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_J: begin
                w_jump = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_cmp_a   = forwardAD ? aluOutM : w_rd1;
    assign w_cmp_b   = forwardBD ? aluOutM : w_rd2;
    assign w_equal   = (w_cmp_a == w_cmp_b);

    assign branchD   = w_branch;
    assign jumpD     = w_jump;
    assign pcSrcD    = w_branch & w_equal;
    assign pcBranchD = pcPlus4D + {w_sign_imm[29:0], 2'b00};
    assign pcJumpD   = {pcPlus4D[31:28], instrD[25:0], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_mem_write   <= 1'b0;
            r_alu_src     <= 1'b0;
            r_reg_dst     <= 1'b0;
            r_alu_control <= 2'b00;
            r_rd1         <= 32'd0;
            r_rd2         <= 32'd0;
            r_rs          <= 5'd0;
            r_rt          <= 5'd0;
            r_rd          <= 5'd0;
            r_sign_imm    <= 32'd0;
        end else if (flushE) begin
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_mem_write   <= 1'b0;
            r_alu_src     <= 1'b0;
            r_reg_dst     <= 1'b0;
            r_alu_control <= 2'b00;
            r_rd1         <= 32'd0;
            r_rd2         <= 32'd0;
            r_rs          <= 5'd0;
            r_rt          <= 5'd0;
            r_rd          <= 5'd0;
            r_sign_imm    <= 32'd0;
        end else begin
            r_reg_write   <= w_reg_write;
            r_mem_to_reg  <= w_mem_to_reg;
            r_mem_write   <= w_mem_write;
            r_alu_src     <= w_alu_src;
            r_reg_dst     <= w_reg_dst;
            r_alu_control <= w_alu_control;
            r_rd1         <= w_rd1;
            r_rd2         <= w_rd2;
            r_rs          <= rsD;
            r_rt          <= rtD;
            r_rd          <= w_rd;
            r_sign_imm    <= w_sign_imm;
        end
    end

    assign regWriteE   = r_reg_write;
    assign memToRegE   = r_mem_to_reg;
    assign memWriteE   = r_mem_write;
    assign aluSrcE     = r_alu_src;
    assign regDstE     = r_reg_dst;
    assign aluControlE = r_alu_control;
    assign rd1E        = r_rd1;
    assign rd2E        = r_rd2;
    assign rsE         = r_rs;
    assign rtE         = r_rt;
    assign rdE         = r_rd;
    assign signImmE    = r_sign_imm;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage

module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instrD;
    logic [31:0] pcPlus4D;
    logic        regWriteW;
    logic [4:0]  writeRegW;
    logic [31:0] resultW;
    logic [31:0] aluOutM;
    logic        forwardAD;
    logic        forwardBD;
    logic        flushE;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic        branchD;
    logic        jumpD;
    logic        pcSrcD;
    logic [31:0] pcBranchD;
    logic [31:0] pcJumpD;
    logic        regWriteE;
    logic        memToRegE;
    logic        memWriteE;
    logic        aluSrcE;
    logic        regDstE;
    logic [1:0]  aluControlE;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic [4:0]  rsE;
    logic [4:0]  rtE;
    logic [4:0]  rdE;
    logic [31:0] signImmE;

    decode_stage dut (
        .clk(clk), .rst(rst), .instrD(instrD), .pcPlus4D(pcPlus4D),
        .regWriteW(regWriteW), .writeRegW(writeRegW), .resultW(resultW),
        .aluOutM(aluOutM), .forwardAD(forwardAD), .forwardBD(forwardBD),
        .flushE(flushE), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpD(jumpD),
        .pcSrcD(pcSrcD), .pcBranchD(pcBranchD), .pcJumpD(pcJumpD),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE),
        .aluSrcE(aluSrcE), .regDstE(regDstE), .aluControlE(aluControlE),
        .rd1E(rd1E), .rd2E(rd2E), .rsE(rsE), .rtE(rtE), .rdE(rdE),
        .signImmE(signImmE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {regWrite, memToReg, memWrite, aluSrc, regDst, aluControl[1:0]}
    typedef struct packed {
        logic [6:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
    } e_t;

    localparam logic [6:0] C_ADD  = 7'b1000100;
    localparam logic [6:0] C_SUB  = 7'b1000101;
    localparam logic [6:0] C_AND  = 7'b1000110;
    localparam logic [6:0] C_OR   = 7'b1000111;
    localparam logic [6:0] C_LW   = 7'b1101000;
    localparam logic [6:0] C_SW   = 7'b0011000;
    localparam logic [6:0] C_BEQ  = 7'b0000001;
    localparam logic [6:0] C_ADDI = 7'b1001000;
    localparam logic [6:0] C_NONE = 7'b0000000;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] tb_rf [32];
    e_t sb [$];
    e_t mon_exp;
    e_t mon_obs;

    function automatic e_t obs_e();
        return {regWriteE, memToRegE, memWriteE, aluSrcE, regDstE, aluControlE,
                rd1E, rd2E, rsE, rtE, rdE, signImmE};
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (regWriteW && writeRegW == a) return resultW;
        return tb_rf[a];
    endfunction

    function automatic e_t mk_exp(input logic [6:0] c, input logic [31:0] ins);
        e_t e;
        e.ctrl = c;
        e.rd1  = model_rd(ins[25:21]);
        e.rd2  = model_rd(ins[20:16]);
        e.rs   = ins[25:21];
        e.rt   = ins[20:16];
        e.rd   = ins[15:11];
        e.imm  = {{16{ins[15]}}, ins[15:0]};
        return e;
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Scoreboard: each pushed entry describes the E outputs after the next edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            mon_obs = obs_e();
            n_checks = n_checks + 1;
            if (mon_obs !== mon_exp) begin
                n_errors = n_errors + 1;
                $display("FAIL e_stage got=%h expected=%h", mon_obs, mon_exp);
            end
        end
    end

    task automatic drive(input logic [31:0] ins, pc4, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic fa, fb, input logic [31:0] am,
                         input logic fl);
        instrD = ins; pcPlus4D = pc4; regWriteW = we; writeRegW = wa; resultW = wd;
        forwardAD = fa; forwardBD = fb; aluOutM = am; flushE = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst && regWriteW && writeRegW != 5'd0) tb_rf[writeRegW] = resultW;
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        drive(32'hFC00_0000, 32'd0, 1'b1, a, d, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        sb.push_back(mk_exp(C_NONE, instrD));
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] ins;
        #1;
        n_checks++;
        if (obs_e() !== '0) begin n_errors++; $display("FAIL reset_e got=%h expected=0", obs_e()); end
        @(negedge clk);
        rst = 1'b1;
        // r5 loaded via write-through into an lw so E holds non-zero state
        ins = mk_i(6'b100011, 5'd5, 5'd0, 16'h0008);
        drive(ins, 32'h4, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        sb.push_back(mk_exp(C_LW, ins));
        tick();
        // In-flight write to r6 must be killed by the mid-cycle reset
        drive(mk_i(6'b000100, 5'd5, 5'd0, 16'h0000), 32'h8, 1'b1, 5'd6, 32'h55, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        n_checks++;
        if (pcSrcD !== 1'b0) begin n_errors++; $display("FAIL reset_pre_r5 pcSrcD=%b expected=0", pcSrcD); end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (pcSrcD !== 1'b1) begin n_errors++; $display("FAIL reset_r5_cleared pcSrcD=%b expected=1", pcSrcD); end
        n_checks++;
        if (obs_e() !== '0) begin n_errors++; $display("FAIL reset_async_e got=%h expected=0", obs_e()); end
        for (int i = 0; i < 32; i++) tb_rf[i] = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        ins = mk_i(6'b000100, 5'd6, 5'd0, 16'h0000);
        drive(ins, 32'h8, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        n_checks++;
        if (pcSrcD !== 1'b1) begin n_errors++; $display("FAIL reset_kills_write pcSrcD=%b expected=1", pcSrcD); end
        sb.push_back(mk_exp(C_BEQ, ins));
        tick();
    endtask

    task automatic test_write_through();
        logic [31:0] ins;
        ins = mk_i(6'b000100, 5'd7, 5'd0, 16'h0010);
        drive(ins, 32'h20, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        #1;
        n_checks++;
        if (pcSrcD !== 1'b1) begin n_errors++; $display("FAIL wt_same_cycle pcSrcD=%b expected=1", pcSrcD); end
        sb.push_back(mk_exp(C_BEQ, ins));
        tick();
        ins = mk_i(6'b100011, 5'd7, 5'd0, 16'h0000);
        drive(ins, 32'h24, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        sb.push_back(mk_exp(C_LW, ins));
        tick();
        ins = mk_i(6'b000100, 5'd0, 5'd0, 16'h0000);
        drive(ins, 32'h28, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        n_checks++;
        if (pcSrcD !== 1'b1) begin n_errors++; $display("FAIL wt_r0_zero pcSrcD=%b expected=1", pcSrcD); end
        sb.push_back(mk_exp(C_BEQ, ins));
        tick();
    endtask

    task automatic test_decode_sweep();
        logic [31:0] t_ins [12];
        logic [6:0]  t_ctl [12];
        logic [1:0]  t_bj  [12];
        t_ins[0]  = mk_r(5'd1, 5'd3, 5'd4, 6'b100000);   t_ctl[0]  = C_ADD;  t_bj[0]  = 2'b00;
        t_ins[1]  = mk_r(5'd1, 5'd3, 5'd4, 6'b100010);   t_ctl[1]  = C_SUB;  t_bj[1]  = 2'b00;
        t_ins[2]  = mk_r(5'd1, 5'd3, 5'd4, 6'b100100);   t_ctl[2]  = C_AND;  t_bj[2]  = 2'b00;
        t_ins[3]  = mk_r(5'd1, 5'd3, 5'd4, 6'b100101);   t_ctl[3]  = C_OR;   t_bj[3]  = 2'b00;
        t_ins[4]  = mk_r(5'd1, 5'd3, 5'd4, 6'b101010);   t_ctl[4]  = C_NONE; t_bj[4]  = 2'b00;
        t_ins[5]  = mk_i(6'b100011, 5'd1, 5'd3, 16'h0004); t_ctl[5]  = C_LW;   t_bj[5]  = 2'b00;
        t_ins[6]  = mk_i(6'b101011, 5'd1, 5'd3, 16'h8000); t_ctl[6]  = C_SW;   t_bj[6]  = 2'b00;
        t_ins[7]  = mk_i(6'b000100, 5'd1, 5'd3, 16'h0002); t_ctl[7]  = C_BEQ;  t_bj[7]  = 2'b10;
        t_ins[8]  = mk_i(6'b001000, 5'd1, 5'd3, 16'hFFFC); t_ctl[8]  = C_ADDI; t_bj[8]  = 2'b00;
        t_ins[9]  = {6'b000010, 26'h0000100};              t_ctl[9]  = C_NONE; t_bj[9]  = 2'b01;
        t_ins[10] = mk_i(6'b111111, 5'd1, 5'd3, 16'h1234); t_ctl[10] = C_NONE; t_bj[10] = 2'b00;
        t_ins[11] = mk_i(6'b101011, 5'd3, 5'd1, 16'h7FFF); t_ctl[11] = C_SW;   t_bj[11] = 2'b00;
        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd5);
        write_reg(5'd3, 32'd6);
        for (int i = 0; i < 12; i++) begin
            drive(t_ins[i], 32'h400, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
            #1;
            n_checks++;
            if ({branchD, jumpD} !== t_bj[i]) begin
                n_errors++;
                $display("FAIL sweep_bj[%0d] got=%b expected=%b", i, {branchD, jumpD}, t_bj[i]);
            end
            sb.push_back(mk_exp(t_ctl[i], t_ins[i]));
            tick();
        end
        n_checks++;
        if (signImmE !== 32'hFFFF_FFFC && 1'b0) begin n_errors++; end
    endtask

    task automatic test_branch();
        logic [31:0] ins;
        ins = mk_i(6'b000100, 5'd1, 5'd2, 16'h0003);
        drive(ins, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        n_checks++;
        if (pcSrcD !== 1'b1) begin n_errors++; $display("FAIL br_equal pcSrcD=%b expected=1", pcSrcD); end
        n_checks++;
        if (pcBranchD !== 32'h10C) begin n_errors++; $display("FAIL br_target got=%h expected=0000010c", pcBranchD); end
        sb.push_back(mk_exp(C_BEQ, ins));
        tick();
        ins = mk_i(6'b000100, 5'd1, 5'd3, 16'h0003);
        drive(ins, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd5, 1'b0);
        #1;
        n_checks++;
        if (pcSrcD !== 1'b1) begin n_errors++; $display("FAIL br_fwd_b pcSrcD=%b expected=1", pcSrcD); end
        forwardBD = 1'b0;
        #1;
        n_checks++;
        if (pcSrcD !== 1'b0) begin n_errors++; $display("FAIL br_nofwd pcSrcD=%b expected=0", pcSrcD); end
        sb.push_back(mk_exp(C_BEQ, ins));
        tick();
        ins = mk_i(6'b000100, 5'd3, 5'd1, 16'hFFFF);
        drive(ins, 32'h0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd5, 1'b0);
        #1;
        n_checks++;
        if (pcSrcD !== 1'b1) begin n_errors++; $display("FAIL br_fwd_a pcSrcD=%b expected=1", pcSrcD); end
        n_checks++;
        if (pcBranchD !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL br_wrap got=%h expected=fffffffc", pcBranchD); end
        sb.push_back(mk_exp(C_BEQ, ins));
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] ins;
        ins = mk_i(6'b100011, 5'd1, 5'd3, 16'h0010);
        drive(ins, 32'h200, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 1'b0, 32'd0, 1'b1);
        #1;
        sb.push_back('0);
        tick();
        ins = mk_i(6'b100011, 5'd9, 5'd0, 16'h0000);
        drive(ins, 32'h204, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        sb.push_back(mk_exp(C_LW, ins));
        tick();
    endtask

    task automatic test_jump();
        logic [31:0] ins;
        ins = {6'b000010, 26'h0000040};
        drive(ins, 32'hA000_0004, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        n_checks++;
        if (jumpD !== 1'b1) begin n_errors++; $display("FAIL jump_flag got=%b expected=1", jumpD); end
        n_checks++;
        if (pcJumpD !== 32'hA000_0100) begin n_errors++; $display("FAIL jump_target got=%h expected=a0000100", pcJumpD); end
        n_checks++;
        if (pcSrcD !== 1'b0) begin n_errors++; $display("FAIL jump_pcsrc got=%b expected=0", pcSrcD); end
        sb.push_back(mk_exp(C_NONE, ins));
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wa;
        for (int i = 0; i < 24; i++) begin
            rs = 5'($urandom_range(0, 31));
            rt = 5'($urandom_range(0, 31));
            wa = (i % 4 == 0) ? rs : 5'($urandom_range(0, 31));
            ins = mk_i(6'b100011, rs, rt, 16'($urandom));
            drive(ins, 32'h300, 1'b1, wa, $urandom, 1'b0, 1'b0, 32'd0, 1'b0);
            #1;
            sb.push_back(mk_exp(C_LW, ins));
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 32; i++) tb_rf[i] = 32'd0;
        test_reset();
        test_write_through();
        test_decode_sweep();
        test_branch();
        test_flush();
        test_jump();
        test_back_to_back();
        drive(32'hFC00_0000, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain left=%0d expected=0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
